mig_ui_responder: RTL
=====================

Name: mig_ui_responder

Overview:
Synthesizable stand-in for the DDR3 MIG user interface. It acts as the responder side of the app_* command/write/read protocol, so frame-buffer initiators can be simulated and brought up on-chip without the real MIG. It models calibration delay, command back-pressure, byte-masked writes into an internal word array, and fixed-latency in-order read returns. It flags protocol violations made by the initiator.

Parameters:
DEPTH_WORDS, 1024, number of 128-bit words in the backing array (word index = app_addr >> 3)
CALIB_CYCLES, 64, cycles from reset release until init_calib_complete rises (>=1)
RD_LATENCY, 8, cycles from read acceptance to app_rd_data_valid (>=1)
STALL_PERIOD, 0, if >0 app_rdy/app_wdf_rdy drop for 1 cycle every STALL_PERIOD cycles; 0 = never stall

Ports:
clk_in  in  1  clock (same domain as the MIG UI clock)
rst_in  in  1  asynchronous active-high reset
app_addr  in  27  command byte-group address; bits [2:0] must be 0
app_cmd  in  3  3'b000 write, 3'b001 read, others illegal
app_en  in  1  command valid
app_wdf_data  in  128  write data
app_wdf_end  in  1  last beat of write data
app_wdf_wren  in  1  write data valid
app_wdf_mask  in  16  byte mask, 1 = byte not written
app_rdy  out  1  command ready
app_wdf_rdy  out  1  write-data ready
app_rd_data  out  128  read data
app_rd_data_valid  out  1  read data valid
app_rd_data_end  out  1  equals app_rd_data_valid
init_calib_complete  out  1  calibration done
app_sr_active, app_ref_ack, app_zq_ack  out  1 each  tied 0
err_out  out  3  sticky violation flags

Behaviour:
- Reset (async assert, sync release): all outputs 0; read pipeline flushed; calib and stall counters cleared; state CALIB. Array contents are NOT reset and survive a reset.
- States: CALIB -> READY when the calib counter reaches CALIB_CYCLES-1. init_calib_complete=1 in READY only. READY is held until reset.
- app_rdy = app_wdf_rdy = (state==READY) && !stall.
- Stall: the stall counter runs 0..STALL_PERIOD-1 in READY only and wraps. stall=1 when counter==STALL_PERIOD-1.
- Command accepted in a cycle with app_en && app_rdy. Nothing is sampled when app_rdy=0.
- Write accept:
  - Requires app_cmd=000, app_wdf_wren=1, app_wdf_end=1 in the same cycle (single-beat, same-cycle data).
  - Byte i of word[idx] is updated with app_wdf_data[8i+7:8i] iff app_wdf_mask[i]=0.
  - A write command without app_wdf_wren sets err_out[2] and is dropped.
  - app_wdf_wren without an accepted write command sets err_out[2].
- Read accept (app_cmd=001):
  - word[idx] is sampled at acceptance and enters a RD_LATENCY-deep shift pipeline.
  - app_rd_data_valid=1 exactly RD_LATENCY cycles after the accept cycle. Returns are in order, and back-to-back accepts give back-to-back returns.
  - When not valid, app_rd_data holds 0.
  - A write to the same word accepted in the cycle after the read does not affect that read's data.
- Same-cycle read and write: impossible by construction (one command per cycle).
- Read data has no back-pressure. The responder never stalls returns.
- Address checks, made at accept:
  - app_addr[2:0]!=0 sets err_out[0].
  - idx>=DEPTH_WORDS sets err_out[1].
  - On either violation, a write is dropped and a read returns 128'h0 with normal timing.
- app_cmd not 000/001 with app_en in READY sets err_out[2] and the command is ignored. app_en in CALIB is ignored with no error.
- err_out bits are sticky until reset.
- Reset mid-operation: in-flight reads are discarded (no valid after reset asserts), and the calibration delay restarts.

Test Plan:
- Calibration: CALIB_CYCLES=64, release reset, hold app_en=1 -> app_rdy/init_calib_complete stay 0 for 64 cycles, then 1. No err_out.
- Write/read: write 128'hDEAD..BEEF at app_addr 27'h18 with mask 0, then read 27'h18 -> app_rd_data_valid pulses for 1 cycle exactly 8 cycles after the read accept, with data DEAD..BEEF.
- Masked write: word 5 = all 0x11, write all 0xFF with mask 16'h00FF, read -> upper 8 bytes 0xFF, lower 8 bytes 0x11.
- Burst: write words 0..7 = index, then issue 8 consecutive reads at addresses 0,8,...,56 -> 8 consecutive valid cycles returning 0..7 in order.
- Stall: STALL_PERIOD=4, keep app_en=1 with reads -> app_rdy low 1 of every 4 cycles, exactly 3 of every 4 accepted, returns match accept order.
- Violations and reset: read 27'h19 -> err_out=3'b001, data 0. Read idx 1024 -> err_out=3'b011. Assert rst_in with 3 reads in flight -> no app_rd_data_valid afterwards, err_out=0, array data still readable after recalibration.

Source files
------------

// File: rtl/mig_ui_responder.sv
// Stand-in for the DDR3 MIG user interface, responder side. It models calibration,
// periodic back-pressure, byte-masked writes, fixed-latency reads and protocol-error flags.
module mig_ui_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int CALIB_CYCLES = 64,
    parameter int RD_LATENCY   = 8,
    parameter int STALL_PERIOD = 0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [26:0]   app_addr,
    input  logic [2:0]    app_cmd,
    input  logic          app_en,
    input  logic [127:0]  app_wdf_data,
    input  logic          app_wdf_end,
    input  logic          app_wdf_wren,
    input  logic [15:0]   app_wdf_mask,
    output logic          app_rdy,
    output logic          app_wdf_rdy,
    output logic [127:0]  app_rd_data,
    output logic          app_rd_data_valid,
    output logic          app_rd_data_end,
    output logic          init_calib_complete,
    output logic          app_sr_active,
    output logic          app_ref_ack,
    output logic          app_zq_ack,
    output logic [2:0]    err_out
);
    localparam int AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW         = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam int SW         = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int STALL_LAST = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic {CALIB, READY} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   calib_cnt_q, calib_cnt_d;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
    logic [2:0]      err_q, err_d;
    logic [RD_LATENCY-1:0]        vld_pipe_q;
    logic [RD_LATENCY-1:0][127:0] rd_pipe_q;
    logic [127:0]    mem_q [DEPTH_WORDS];

    logic        stall, rdy, acc, wr_cmd, rd_cmd, wr_ok, wr_do, misalign, oob, addr_bad;
    logic [23:0] idx;
    logic [127:0] rd_word;

    assign stall    = (STALL_PERIOD > 0) && (stall_cnt_q == SW'(STALL_LAST));
    assign rdy      = (state_q == READY) && !stall;
    assign acc      = app_en && rdy;
    assign wr_cmd   = acc && (app_cmd == CMD_WR);
    assign rd_cmd   = acc && (app_cmd == CMD_RD);
    assign wr_ok    = wr_cmd && app_wdf_wren && app_wdf_end;
    assign idx      = app_addr[26:3];
    assign misalign = |app_addr[2:0];
    assign oob      = idx >= 24'(DEPTH_WORDS);
    assign addr_bad = misalign || oob;
    assign wr_do    = wr_ok && !addr_bad;
    // Bad addresses still occupy a pipeline slot so read timing stays uniform.
    assign rd_word  = addr_bad ? '0 : mem_q[idx[AW-1:0]];

    always_comb begin
        state_d     = state_q;
        calib_cnt_d = calib_cnt_q;
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        if (state_q == CALIB) begin
            if (calib_cnt_q == CW'(CALIB_CYCLES - 1)) state_d = READY;
            else calib_cnt_d = calib_cnt_q + 1'b1;
        end else if (STALL_PERIOD > 0) begin
            stall_cnt_d = stall ? '0 : stall_cnt_q + 1'b1;
        end
        if ((rd_cmd || wr_ok) && misalign) err_d[0] = 1'b1;
        if ((rd_cmd || wr_ok) && oob)      err_d[1] = 1'b1;
        if (acc && app_cmd != CMD_WR && app_cmd != CMD_RD) err_d[2] = 1'b1;
        if (wr_cmd && !(app_wdf_wren && app_wdf_end))      err_d[2] = 1'b1;
        if (rdy && app_wdf_wren && !wr_cmd)                err_d[2] = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= CALIB;
            calib_cnt_q <= '0;
            stall_cnt_q <= '0;
            err_q       <= '0;
            vld_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            calib_cnt_q <= calib_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
            for (int i = RD_LATENCY - 1; i > 0; i--) vld_pipe_q[i] <= vld_pipe_q[i-1];
            vld_pipe_q[0] <= rd_cmd;
        end
    end

    // Array and read-data pipe carry no reset; the array must survive reset.
    always_ff @(posedge clk_in) begin
        if (wr_do) begin
            for (int b = 0; b < 16; b++)
                if (!app_wdf_mask[b]) mem_q[idx[AW-1:0]][8*b +: 8] <= app_wdf_data[8*b +: 8];
        end
        for (int i = RD_LATENCY - 1; i > 0; i--) rd_pipe_q[i] <= rd_pipe_q[i-1];
        rd_pipe_q[0] <= rd_word;
    end

    assign app_rdy             = rdy;
    assign app_wdf_rdy         = rdy;
    assign app_rd_data_valid   = vld_pipe_q[RD_LATENCY-1];
    assign app_rd_data_end     = vld_pipe_q[RD_LATENCY-1];
    assign app_rd_data         = vld_pipe_q[RD_LATENCY-1] ? rd_pipe_q[RD_LATENCY-1] : '0;
    assign init_calib_complete = (state_q == READY);
    assign app_sr_active       = 1'b0;
    assign app_ref_ack         = 1'b0;
    assign app_zq_ack          = 1'b0;
    assign err_out             = err_q;
endmodule
